// File: rtl/xil_mmreq_bridge_pkg.sv
// Shared state encoding and response-word field positions for the mmreq bridge.
package mmbridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W1,
        BUS,
        R0,
        R1
    } state_t;

    localparam int WR_BIT   = 31;
    localparam int ERR_BIT  = 30;
    localparam int TAG_MSB  = 27;
    localparam int TAG_LSB  = 24;
    localparam int ADDR_MSB = 23;

    // Response word0 always carries the full 24-bit address field, zero-extended.
    function automatic logic [31:0] respWord0(input logic wr,
                                              input logic err,
                                              input logic [3:0] tag,
                                              input logic [ADDR_MSB:0] addr);
        logic [31:0] w;
        w = '0;
        w[WR_BIT] = wr;
        w[ERR_BIT] = err;
        w[TAG_MSB:TAG_LSB] = tag;
        w[ADDR_MSB:0] = addr;
        return w;
    endfunction

endpackage

// File: rtl/xil_mmreq_bridge_if.sv
// Request FIFO, response FIFO and register-bus signals of the mmreq bridge.
interface xil_mmreq_bridge_if #(
    parameter int ADDR_BITS = 24
);
    logic [31:0]          req_data;
    logic                 req_empty;
    logic                 req_rden;
    logic                 req_open;
    logic [31:0]          resp_data;
    logic                 resp_wren;
    logic                 resp_full;
    logic [ADDR_BITS-1:0] bus_addr;
    logic [31:0]          bus_wdata;
    logic                 bus_wr;
    logic                 bus_valid;
    logic                 bus_ack;
    logic [31:0]          bus_rdata;

    modport master (
        input  req_data, req_empty, req_open, resp_full, bus_ack, bus_rdata,
        output req_rden, resp_data, resp_wren, bus_addr, bus_wdata, bus_wr, bus_valid
    );

    modport slave (
        output req_data, req_empty, req_open, resp_full, bus_ack, bus_rdata,
        input  req_rden, resp_data, resp_wren, bus_addr, bus_wdata, bus_wr, bus_valid
    );
endinterface

// File: rtl/xil_mmreq_bridge_timer.sv
// Bus-wait watchdog: cleared on BUS entry, counts BUS cycles without an ack.
module mmbridge_timer #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= count_q + CW'(1);
        end
    end

    // Fires in the cycle whose increment would reach TIMEOUT_CYCLES.
    assign expired = run && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/xil_mmreq_bridge.sv
// Pairs mmreq words into register-bus transactions and returns a 2-word response.
// Optional bus timeout is enabled by defining MMBRIDGE_TIMEOUT_EN.
module xil_mmreq_bridge
    import mmbridge_pkg::*;
#(
    parameter int ADDR_BITS      = 24,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               rst,
    xil_mmreq_bridge_if.master mm
);
    state_t               state_q;
    logic                 wr_q;
    logic                 err_q;
    logic [3:0]           tag_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          data_q;
    logic                 busValid_q;
    logic [ADDR_BITS-1:0] busAddr_q;
    logic [31:0]          busWdata_q;
    logic                 busWr_q;

    logic popReq;
    logic pushResp;
    logic timedOut;

    // FIFO strobes depend on the live empty/full flags so they can never pop empty or push full.
    assign popReq   = !rst && !mm.req_empty && mm.req_open && (state_q == IDLE || state_q == W1);
    assign pushResp = !rst && !mm.resp_full && (state_q == R0 || state_q == R1);

    assign mm.req_rden  = popReq;
    assign mm.resp_wren = pushResp;
    assign mm.resp_data = (state_q == R0) ? respWord0(wr_q, err_q, tag_q, (ADDR_MSB + 1)'(addr_q)) :
                          (state_q == R1) ? data_q : 32'h0;
    assign mm.bus_valid = busValid_q;
    assign mm.bus_addr  = busAddr_q;
    assign mm.bus_wdata = busWdata_q;
    assign mm.bus_wr    = busWr_q;

`ifdef MMBRIDGE_TIMEOUT_EN
    logic timerStart;
    logic timerRun;

    assign timerStart = (state_q == W1) && popReq;
    assign timerRun   = (state_q == BUS) && !mm.bus_ack;

    mmbridge_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (timerStart),
        .run    (timerRun),
        .expired(timedOut)
    );
`else
    assign timedOut = 1'b0;
`endif

    // data_q holds the write data until the bus completes, then becomes response word1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            tag_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            busValid_q <= 1'b0;
            busAddr_q  <= '0;
            busWdata_q <= '0;
            busWr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (popReq) begin
                        wr_q    <= mm.req_data[WR_BIT];
                        tag_q   <= mm.req_data[TAG_MSB:TAG_LSB];
                        addr_q  <= mm.req_data[ADDR_BITS-1:0];
                        err_q   <= 1'b0;
                        state_q <= W1;
                    end
                end
                W1: begin
                    if (!mm.req_open) begin
                        state_q <= IDLE;
                    end else if (popReq) begin
                        data_q     <= mm.req_data;
                        busValid_q <= 1'b1;
                        busAddr_q  <= addr_q;
                        busWdata_q <= mm.req_data;
                        busWr_q    <= wr_q;
                        state_q    <= BUS;
                    end
                end
                BUS: begin
                    if (mm.bus_ack) begin
                        busValid_q <= 1'b0;
                        if (!wr_q) begin
                            data_q <= mm.bus_rdata;
                        end
                        state_q <= R0;
                    end else if (timedOut) begin
                        busValid_q <= 1'b0;
                        err_q      <= 1'b1;
                        data_q     <= '0;
                        state_q    <= R0;
                    end
                end
                R0: begin
                    if (pushResp) begin
                        state_q <= R1;
                    end
                end
                R1: begin
                    if (pushResp) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xil_mmreq_bridge.sv
// Scoreboard bench for xil_mmreq_bridge: FIFO/bus models push expectations, monitors check them.
module tb_xil_mmreq_bridge;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } bus_exp_t;

    logic clk;
    logic rst;

    xil_mmreq_bridge_if #(.ADDR_BITS(24)) mm ();

    xil_mmreq_bridge #(
        .ADDR_BITS     (24),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mm (mm)
    );

    logic [31:0] reqFifo[$];
    logic [31:0] expResp[$];
    bus_exp_t    expBus[$];

    int  assertCount = 0;
    int  failCount = 0;
    int  respWrenCount = 0;
    int  busTxnCount = 0;
    bit  popNext = 0;
    bit  ackEnable = 1;
    bit  strayAckReq = 0;
    bit  busSeen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] r0, input logic [31:0] r1,
                                 input bus_exp_t be);
        expBus.push_back(be);
        expResp.push_back(r0);
        expResp.push_back(r1);
        reqFifo.push_back(w0);
        reqFifo.push_back(w1);
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while ((expResp.size() != 0 || expBus.size() != 0 || reqFifo.size() != 0) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("waitIdleTimeout", 32'(n >= maxCycles), 32'h0);
    endtask

    task automatic waitBusValid(input int maxCycles);
        int n = 0;
        while (!mm.bus_valid && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("waitBusValidTimeout", 32'(mm.bus_valid), 32'h1);
    endtask

    task automatic resetInBus();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstBusValid", 32'(mm.bus_valid), 32'h0);
        checkOutput("rstReqRden", 32'(mm.req_rden), 32'h0);
        checkOutput("rstRespWren", 32'(mm.resp_wren), 32'h0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Request FIFO model: pops are decided at the negedge and applied just after the posedge.
    always @(negedge clk) begin
        popNext = mm.req_rden;
        if (mm.req_rden && mm.req_empty) begin
            checkOutput("rdenWhileEmpty", 32'h1, 32'h0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (popNext && reqFifo.size() != 0) begin
            void'(reqFifo.pop_front());
        end
        popNext = 0;
        mm.req_empty = (reqFifo.size() == 0);
        mm.req_data = (reqFifo.size() != 0) ? reqFifo[0] : 32'h0;
    end

    // Response monitor: every pushed word must match the next scoreboard entry.
    always @(negedge clk) begin
        if (mm.resp_wren) begin
            respWrenCount++;
            if (mm.resp_full) begin
                checkOutput("wrenWhileFull", 32'h1, 32'h0);
            end
            if (expResp.size() == 0) begin
                checkOutput("unexpectedResp", mm.resp_data, 32'hxxxx_xxxx);
            end else begin
                checkOutput("respWord", mm.resp_data, expResp.pop_front());
            end
        end
    end

    // Register-bus responder: checks the request on first sight and acks after the programmed delay.
    initial begin
        bus_exp_t be;
        mm.bus_ack = 1'b0;
        mm.bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mm.bus_valid && !busSeen) begin
                busSeen = 1;
                if (expBus.size() == 0) begin
                    checkOutput("unexpectedBusValid", 32'h1, 32'h0);
                end else begin
                    be = expBus.pop_front();
                    checkOutput("busAddr", 32'(mm.bus_addr), be.addr);
                    checkOutput("busWr", 32'(mm.bus_wr), 32'(be.wr));
                    checkOutput("busWdata", mm.bus_wdata, be.wdata);
                    if (ackEnable) begin
                        repeat (be.delay) @(negedge clk);
                        mm.bus_rdata = be.rdata;
                        mm.bus_ack = 1'b1;
                        @(negedge clk);
                        mm.bus_ack = 1'b0;
                        mm.bus_rdata = 32'h0;
                        busTxnCount++;
                        checkOutput("busValidDrop", 32'(mm.bus_valid), 32'h0);
                        busSeen = 0;
                    end
                end
            end else if (!mm.bus_valid) begin
                busSeen = 0;
                if (strayAckReq) begin
                    mm.bus_ack = 1'b1;
                    mm.bus_rdata = 32'hFFFF_FFFF;
                    @(negedge clk);
                    mm.bus_ack = 1'b0;
                    mm.bus_rdata = 32'h0;
                    strayAckReq = 0;
                end
            end
        end
    end

    initial begin
        int snapResp;
        int snapTxn;
        int n;
        rst = 1'b1;
        mm.req_open = 1'b1;
        mm.resp_full = 1'b0;
        mm.req_empty = 1'b1;
        mm.req_data = 32'h0;
        repeat (3) @(negedge clk);

        checkOutput("resetReqRden", 32'(mm.req_rden), 32'h0);
        checkOutput("resetRespWren", 32'(mm.resp_wren), 32'h0);
        checkOutput("resetRespData", mm.resp_data, 32'h0);
        checkOutput("resetBusValid", 32'(mm.bus_valid), 32'h0);
        checkOutput("resetBusAddr", 32'(mm.bus_addr), 32'h0);
        checkOutput("resetBusWdata", mm.bus_wdata, 32'h0);
        checkOutput("resetBusWr", 32'(mm.bus_wr), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] read, write and reserved-bit transactions");
        applyStimulus(32'h0300_0010, 32'h0, 32'h0300_0010, 32'hDEAD_BEEF,
                      '{addr: 32'h10, wr: 1'b0, wdata: 32'h0, rdata: 32'hDEAD_BEEF, delay: 3});
        waitIdle(200);
        applyStimulus(32'h8500_0024, 32'h1234_5678, 32'h8500_0024, 32'h1234_5678,
                      '{addr: 32'h24, wr: 1'b1, wdata: 32'h1234_5678, rdata: 32'hAAAA_5555, delay: 0});
        applyStimulus(32'h7FAB_CDEF, 32'h9999_9999, 32'h0FAB_CDEF, 32'h0102_0304,
                      '{addr: 32'hAB_CDEF, wr: 1'b0, wdata: 32'h9999_9999, rdata: 32'h0102_0304, delay: 1});
        waitIdle(200);

        $display("[TB] partial pair discarded when req_open drops");
        snapResp = respWrenCount;
        snapTxn = busTxnCount;
        reqFifo.push_back(32'h0000_0004);
        repeat (5) @(negedge clk);
        mm.req_open = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("partialNoResp", 32'(respWrenCount - snapResp), 32'h0);
        checkOutput("partialNoBus", 32'(busTxnCount - snapTxn), 32'h0);
        checkOutput("partialNoValid", 32'(mm.bus_valid), 32'h0);
        mm.req_open = 1'b1;
        applyStimulus(32'h8300_0008, 32'hCAFE_F00D, 32'h8300_0008, 32'hCAFE_F00D,
                      '{addr: 32'h8, wr: 1'b1, wdata: 32'hCAFE_F00D, rdata: 32'h0, delay: 2});
        waitIdle(200);

        $display("[TB] stray ack while idle");
        snapResp = respWrenCount;
        strayAckReq = 1;
        repeat (6) @(negedge clk);
        checkOutput("strayAckNoResp", 32'(respWrenCount - snapResp), 32'h0);

        $display("[TB] response back-pressure");
        mm.resp_full = 1'b1;
        snapResp = respWrenCount;
        snapTxn = busTxnCount;
        applyStimulus(32'h0200_0030, 32'h0, 32'h0200_0030, 32'h55AA_55AA,
                      '{addr: 32'h30, wr: 1'b0, wdata: 32'h0, rdata: 32'h55AA_55AA, delay: 2});
        n = 0;
        while (busTxnCount == snapTxn && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bpAckSeen", 32'(busTxnCount - snapTxn), 32'h1);
        repeat (20) @(negedge clk);
        checkOutput("bpNoWren", 32'(respWrenCount - snapResp), 32'h0);
        mm.resp_full = 1'b0;
        waitIdle(200);
        checkOutput("bpTwoWords", 32'(respWrenCount - snapResp), 32'h2);

        ackEnable = 0;
`ifdef MMBRIDGE_TIMEOUT_EN
        $display("[TB] bus timeout");
        applyStimulus(32'h0B00_00AA, 32'h7777_7777, 32'h4B00_00AA, 32'h0,
                      '{addr: 32'hAA, wr: 1'b0, wdata: 32'h7777_7777, rdata: 32'h0, delay: 0});
        waitBusValid(100);
        n = 0;
        while (mm.bus_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("timeoutCycles", 32'(n), 32'd15);
        waitIdle(200);
`else
        $display("[TB] no timeout: bus waits indefinitely");
        expBus.push_back('{addr: 32'hAA, wr: 1'b0, wdata: 32'h7777_7777, rdata: 32'h0, delay: 0});
        reqFifo.push_back(32'h0B00_00AA);
        reqFifo.push_back(32'h7777_7777);
        waitBusValid(100);
        n = 0;
        while (mm.bus_valid && n < 1000) begin
            n++;
            @(negedge clk);
        end
        checkOutput("noTimeoutHeld", 32'(n), 32'd1000);
        resetInBus();
`endif

        $display("[TB] reset during BUS");
        expBus.push_back('{addr: 32'h40, wr: 1'b0, wdata: 32'h11, rdata: 32'h0, delay: 0});
        reqFifo.push_back(32'h0100_0040);
        reqFifo.push_back(32'h0000_0011);
        waitBusValid(100);
        repeat (3) @(negedge clk);
        resetInBus();
        ackEnable = 1;
        applyStimulus(32'h8C00_0050, 32'h0BAD_F00D, 32'h8C00_0050, 32'h0BAD_F00D,
                      '{addr: 32'h50, wr: 1'b1, wdata: 32'h0BAD_F00D, rdata: 32'h0, delay: 1});
        waitIdle(200);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
